// File: rtl/muldiv_pkg.sv
// Shared constants for the multi-cycle multiply/divide sequencer and the ALU control decode.
package muldiv_pkg;

  localparam logic [3:0] ALU_MULT = 4'b0101;
  localparam logic [3:0] ALU_DIV  = 4'b1011;

  // Quotient reported for a zero divisor; consumers slice it down to their width.
  localparam logic [63:0] DIV0_QUOTIENT = '1;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_MUL  = 3'd1;
  localparam state_t ST_DIV  = 3'd2;
  localparam state_t ST_FIX  = 3'd3;
  localparam state_t ST_DONE = 3'd4;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the EX stage and the multiply/divide sequencer.
interface muldiv_sequencer_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
);
  // Handshake: start is a request sampled only while the sequencer is idle; once it is
  // accepted busy stalls the pipeline, and done pulses for one cycle with hi/lo valid.
  logic             start;
  logic [3:0]       alu_ctrl;
  logic             flush;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  state_t           dbg_state;

  modport master (
    output start, alu_ctrl, flush, op_a, op_b,
    input  busy, done, hi, lo, dbg_state
  );

  modport slave (
    input  start, alu_ctrl, flush, op_a, op_b,
    output busy, done, hi, lo, dbg_state
  );
endinterface

// File: rtl/muldiv_negate.sv
// Conditional two's complement of a W-bit value.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);
  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiply / restoring divide with HI/LO result registers.
// Build option MULDIV_SIGNED_EN selects two's complement operands with sign fix-up.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  muldiv_sequencer_if.slave  bus
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               req_q, req_d;
  logic               is_div_q, is_div_d;
  logic               div0_q, div0_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               is_mult, is_divc;

`ifdef MULDIV_SIGNED_EN
  assign sign_a = bus.op_a[WIDTH-1];
  assign sign_b = bus.op_b[WIDTH-1];
`else
  assign sign_a = 1'b0;
  assign sign_b = 1'b0;
`endif

  assign mag_a   = sign_a ? (~bus.op_a + WIDTH'(1)) : bus.op_a;
  assign mag_b   = sign_b ? (~bus.op_b + WIDTH'(1)) : bus.op_b;
  assign is_mult = (bus.alu_ctrl == ALU_MULT);
  assign is_divc = (bus.alu_ctrl == ALU_DIV);

  // Multiply: upper half accumulates, multiplier bits shift out of the low half.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  // Divide: dividend bits shift out of the low half into the partial remainder.
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  muldiv_negate #(.W(2*WIDTH)) u_neg_prod (.val_i(acc_q),            .neg_i(neg_q),     .val_o(prod_fix));
  muldiv_negate #(.W(WIDTH))   u_neg_quo  (.val_i(acc_q[WIDTH-1:0]), .neg_i(neg_q),     .val_o(quo_fix));
  muldiv_negate #(.W(WIDTH))   u_neg_rem  (.val_i(rem_q),            .neg_i(neg_rem_q), .val_o(rem_fix));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    req_d     = req_q;
    is_div_d  = is_div_q;
    div0_d    = div0_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      ST_IDLE: begin
        // Accepted requests wait one cycle here before the stall begins.
        if (req_q) begin
          req_d = 1'b0;
          cnt_d = '0;
          if (div0_q) begin
            state_d = ST_DONE;
            hi_d    = acc_q[WIDTH-1:0];
            lo_d    = DIV0_QUOTIENT[WIDTH-1:0];
          end else begin
            state_d = is_div_q ? ST_DIV : ST_MUL;
          end
        end else if (bus.start && (is_mult || is_divc)) begin
          req_d     = 1'b1;
          is_div_d  = is_divc;
          div0_d    = is_divc && (bus.op_b == '0);
          neg_d     = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          rem_d     = '0;
          opnd_d    = is_divc ? mag_b : mag_a;
          if (is_divc && (bus.op_b == '0)) acc_d = {{WIDTH{1'b0}}, bus.op_a};
          else                             acc_d = {{WIDTH{1'b0}}, is_divc ? mag_a : mag_b};
        end
      end
      ST_MUL, ST_DIV: begin
        if (state_q == ST_MUL) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
          rem_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_DONE;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A squash abandons the operation without touching hi/lo.
    if (bus.flush && (state_q == ST_MUL || state_q == ST_DIV || state_q == ST_FIX)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      req_q     <= 1'b0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      req_q     <= req_d;
      is_div_q  <= is_div_d;
      div0_q    <= div0_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign bus.busy      = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer; expected values follow MULDIV_SIGNED_EN when defined.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.alu_ctrl = ctrl;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    do begin
      tick();
      lat++;
      if (bus.busy) busy_cycles++;
    end while (!bus.done && lat < 100);
  endtask

  initial begin
    int lat;
    int bc;
    int pre;
    logic seen_done;
    checks   = 0;
    failures = 0;
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.flush    = 1'b0;
    bus.alu_ctrl = 4'b0000;
    bus.op_a     = '0;
    bus.op_b     = '0;
    repeat (3) tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_state", 64'(bus.dbg_state), 64'(ST_IDLE));
    reset_n = 1'b1;
    tick();

    // mult 7*6
    launch(ALU_MULT, 32'd7, 32'd6);
    check("mul_busy_t", 64'(bus.busy), 64'd0);
    wait_done(lat, bc);
    check("mul_latency", 64'(lat), 64'd34);
    check("mul_busy_cycles", 64'(bc), 64'd33);
    check("mul_hi", 64'(bus.hi), 64'd0);
    check("mul_lo", 64'(bus.lo), 64'd42);
    tick();
    check("mul_done_1cyc", 64'(bus.done), 64'd0);

    // zero operand: no early out
    launch(ALU_MULT, 32'd0, 32'd5);
    wait_done(lat, bc);
    check("mul0_latency", 64'(lat), 64'd34);
    check("mul0_lo", 64'(bus.lo), 64'd0);
    tick();

    // div 100/7 (signed build: -100/7)
`ifdef MULDIV_SIGNED_EN
    launch(ALU_DIV, 32'hFFFFFF9C, 32'd7);
    wait_done(lat, bc);
    check("div_lo", 64'(bus.lo), 64'hFFFFFFF2);
    check("div_hi", 64'(bus.hi), 64'hFFFFFFFE);
`else
    launch(ALU_DIV, 32'd100, 32'd7);
    wait_done(lat, bc);
    check("div_lo", 64'(bus.lo), 64'd14);
    check("div_hi", 64'(bus.hi), 64'd2);
`endif
    check("div_latency", 64'(lat), 64'd34);
    tick();

    // divide by zero
    launch(ALU_DIV, 32'd5, 32'd0);
    wait_done(lat, bc);
    check("div0_latency", 64'(lat), 64'd1);
    check("div0_busy", 64'(bc), 64'd0);
    check("div0_hi", 64'(bus.hi), 64'd5);
    check("div0_lo", 64'(bus.lo), 64'hFFFFFFFF);
    tick();

    // most-negative dividend by -1
    launch(ALU_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, bc);
`ifdef MULDIV_SIGNED_EN
    check("divmin_lo", 64'(bus.lo), 64'h80000000);
    check("divmin_hi", 64'(bus.hi), 64'd0);
`else
    check("divmin_lo", 64'(bus.lo), 64'd0);
    check("divmin_hi", 64'(bus.hi), 64'h80000000);
`endif
    tick();

    // all-ones squared
    launch(ALU_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, bc);
`ifdef MULDIV_SIGNED_EN
    check("mulmax_hi", 64'(bus.hi), 64'd0);
    check("mulmax_lo", 64'(bus.lo), 64'd1);
`else
    check("mulmax_hi", 64'(bus.hi), 64'hFFFFFFFE);
    check("mulmax_lo", 64'(bus.lo), 64'h00000001);
`endif
    tick();

    // mult -7*3
    launch(ALU_MULT, 32'hFFFFFFF9, 32'd3);
    wait_done(lat, bc);
`ifdef MULDIV_SIGNED_EN
    check("mulneg_hi", 64'(bus.hi), 64'hFFFFFFFF);
`else
    check("mulneg_hi", 64'(bus.hi), 64'h00000002);
`endif
    check("mulneg_lo", 64'(bus.lo), 64'hFFFFFFEB);
    tick();

    // stray alu_ctrl: start is a no-op
    launch(4'b0010, 32'd9, 32'd9);
    repeat (3) tick();
    check("stray_state", 64'(bus.dbg_state), 64'(ST_IDLE));
    check("stray_busy", 64'(bus.busy), 64'd0);
    check("stray_lo_kept", 64'(bus.lo), 64'hFFFFFFEB);

    // second start during MUL is ignored
    launch(ALU_MULT, 32'd12, 32'd11);
    repeat (5) tick();
    bus.alu_ctrl = ALU_DIV;
    bus.op_a     = 32'd9;
    bus.op_b     = 32'd3;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    pre = 6;
    wait_done(lat, bc);
    check("mul2_latency", 64'(pre + lat), 64'd34);
    check("mul2_hi", 64'(bus.hi), 64'd0);
    check("mul2_lo", 64'(bus.lo), 64'd132);
    repeat (3) tick();
    check("mul2_back_idle", 64'(bus.dbg_state), 64'(ST_IDLE));

    // flush at iteration 10
    launch(ALU_MULT, 32'd3, 32'd3);
    repeat (11) tick();
    check("flush_in_mul", 64'(bus.dbg_state), 64'(ST_MUL));
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_state", 64'(bus.dbg_state), 64'(ST_IDLE));
    check("flush_busy", 64'(bus.busy), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) seen_done = 1'b1;
    end
    check("flush_no_done", 64'(seen_done), 64'd0);
    check("flush_hi_kept", 64'(bus.hi), 64'd0);
    check("flush_lo_kept", 64'(bus.lo), 64'd132);

    // asynchronous reset mid-DIV
    launch(ALU_DIV, 32'd1000, 32'd3);
    repeat (10) tick();
    check("rst_mid_busy_pre", 64'(bus.busy), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid_busy", 64'(bus.busy), 64'd0);
    check("rstmid_done", 64'(bus.done), 64'd0);
    check("rstmid_hi", 64'(bus.hi), 64'd0);
    check("rstmid_lo", 64'(bus.lo), 64'd0);
    check("rstmid_state", 64'(bus.dbg_state), 64'(ST_IDLE));
    tick();
    reset_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
